// File: rtl/timer_pkg.sv
// Shared types and constants for the HH:MM:SS timer control block.
// Optional lap capture in timer_ctrl is enabled by defining TIMER_CTRL_LAP_EN.
package timer_pkg;

  localparam int HW = 7;
  localparam int MW = 6;
  localparam int SW = 6;

  localparam int HOURS_MAX = 99;
  localparam int MIN_MAX   = 59;
  localparam int SEC_MAX   = 59;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_EDIT_H = 3'd3,
    ST_EDIT_M = 3'd4,
    ST_EDIT_S = 3'd5,
    ST_ALARM  = 3'd6
  } state_e;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_H    = 2'd1;
  localparam logic [1:0] FLD_M    = 2'd2;
  localparam logic [1:0] FLD_S    = 2'd3;

  // Winning button after priority resolution; only one acts per cycle.
  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_CLR   = 3'd1,
    BTN_MODE  = 3'd2,
    BTN_START = 3'd3,
    BTN_INC   = 3'd4,
    BTN_LAP   = 3'd5
  } btn_e;

  // clr > mode > start > inc > lap
  function automatic btn_e btn_pick(input logic clr, input logic mode,
                                    input logic start, input logic inc,
                                    input logic lap);
    btn_e b;
    if (clr)        b = BTN_CLR;
    else if (mode)  b = BTN_MODE;
    else if (start) b = BTN_START;
    else if (inc)   b = BTN_INC;
    else if (lap)   b = BTN_LAP;
    else            b = BTN_NONE;
    return b;
  endfunction

endpackage

// File: rtl/timer_field_inc.sv
// Wrap-around increment of one time field: MAX wraps to 0.
module timer_field_inc #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic [W-1:0] val_i,
  output logic [W-1:0] nxt_o
);

  assign nxt_o = (val_i >= W'(MAX)) ? '0 : val_i + W'(1);

endmodule

// File: rtl/timer_ctrl.sv
// Control FSM for the HH:MM:SS up-counting timer: run/pause/clear, alarm
// target editing, match detection and timed alarm.
// Define TIMER_CTRL_LAP_EN to enable lap capture on i_btn_lap.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_btn_start,
  input  logic          i_btn_mode,
  input  logic          i_btn_inc,
  input  logic          i_btn_clr,
  input  logic          i_btn_lap,
  input  logic          i_sec_tick,
  input  logic [HW-1:0] i_hours,
  input  logic [MW-1:0] i_minutes,
  input  logic [SW-1:0] i_seconds,
  output logic          o_run,
  output logic          o_load,
  output logic [HW-1:0] o_load_hours,
  output logic [MW-1:0] o_load_minutes,
  output logic [SW-1:0] o_load_seconds,
  output logic [HW-1:0] o_tgt_hours,
  output logic [MW-1:0] o_tgt_minutes,
  output logic [SW-1:0] o_tgt_seconds,
  output logic [1:0]    o_edit_field,
  output logic          o_alarm,
  output logic [HW-1:0] o_lap_hours,
  output logic [MW-1:0] o_lap_minutes,
  output logic [SW-1:0] o_lap_seconds
);

  state_e        state_q, state_d;
  logic          tick_d_q;
  logic [HW-1:0] tgt_h_q, tgt_h_d, tgt_h_inc;
  logic [MW-1:0] tgt_m_q, tgt_m_d, tgt_m_inc;
  logic [SW-1:0] tgt_s_q, tgt_s_d, tgt_s_inc;
  logic [7:0]    cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          load_q, load_d;
  logic          alarm_q, alarm_d;
  logic [1:0]    fld_q, fld_d;
  logic          lap_btn, lap_cap, lap_clr;
  logic          match;
  btn_e          btn;

`ifdef TIMER_CTRL_LAP_EN
  assign lap_btn = i_btn_lap;
`else
  assign lap_btn = 1'b0;
`endif

  assign btn = btn_pick(i_btn_clr, i_btn_mode, i_btn_start, i_btn_inc, lap_btn);

  // Compare on the cycle after the tick, once the datapath has advanced.
  assign match = (state_q == ST_RUN) && tick_d_q &&
                 (|{tgt_h_q, tgt_m_q, tgt_s_q}) &&
                 (i_hours == tgt_h_q) && (i_minutes == tgt_m_q) &&
                 (i_seconds == tgt_s_q);

  timer_field_inc #(.W(HW), .MAX(HOURS_MAX)) u_inc_h (.val_i(tgt_h_q), .nxt_o(tgt_h_inc));
  timer_field_inc #(.W(MW), .MAX(MIN_MAX))   u_inc_m (.val_i(tgt_m_q), .nxt_o(tgt_m_inc));
  timer_field_inc #(.W(SW), .MAX(SEC_MAX))   u_inc_s (.val_i(tgt_s_q), .nxt_o(tgt_s_inc));

  // Next-state, target edit and alarm countdown
  always_comb begin
    state_d = state_q;
    tgt_h_d = tgt_h_q;
    tgt_m_d = tgt_m_q;
    tgt_s_d = tgt_s_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    lap_cap = 1'b0;
    lap_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        case (btn)
          BTN_CLR:   load_d  = 1'b1;
          BTN_MODE:  state_d = ST_EDIT_H;
          BTN_START: state_d = ST_RUN;
          default: ;
        endcase
      end
      ST_RUN, ST_PAUSED: begin
        if (match) begin
          // Time-critical: a match wins over any button in the same cycle.
          state_d = ST_ALARM;
          cnt_d   = 8'(ALARM_SECS);
        end else begin
          case (btn)
            BTN_CLR: begin
              load_d  = 1'b1;
              lap_clr = 1'b1;
              state_d = ST_IDLE;
            end
            BTN_START: state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
            BTN_LAP:   lap_cap = 1'b1;
            default: ;
          endcase
        end
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        case (btn)
          BTN_CLR: begin
            tgt_h_d = '0;
            tgt_m_d = '0;
            tgt_s_d = '0;
            state_d = ST_IDLE;
          end
          BTN_MODE: begin
            if (state_q == ST_EDIT_H)      state_d = ST_EDIT_M;
            else if (state_q == ST_EDIT_M) state_d = ST_EDIT_S;
            else                           state_d = ST_IDLE;
          end
          BTN_INC: begin
            if (state_q == ST_EDIT_H)      tgt_h_d = tgt_h_inc;
            else if (state_q == ST_EDIT_M) tgt_m_d = tgt_m_inc;
            else                           tgt_s_d = tgt_s_inc;
          end
          default: ;
        endcase
      end
      ST_ALARM: begin
        if (btn != BTN_NONE) begin
          // Acknowledge only; the button has no other effect.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (i_sec_tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state so they line up with it
  always_comb begin
    run_d   = (state_d == ST_RUN);
    alarm_d = (state_d == ST_ALARM);
    case (state_d)
      ST_EDIT_H: fld_d = FLD_H;
      ST_EDIT_M: fld_d = FLD_M;
      ST_EDIT_S: fld_d = FLD_S;
      default:   fld_d = FLD_NONE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      tick_d_q <= 1'b0;
      tgt_h_q  <= '0;
      tgt_m_q  <= '0;
      tgt_s_q  <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      load_q   <= 1'b0;
      alarm_q  <= 1'b0;
      fld_q    <= FLD_NONE;
    end else begin
      state_q  <= state_d;
      tick_d_q <= i_sec_tick;
      tgt_h_q  <= tgt_h_d;
      tgt_m_q  <= tgt_m_d;
      tgt_s_q  <= tgt_s_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      load_q   <= load_d;
      alarm_q  <= alarm_d;
      fld_q    <= fld_d;
    end
  end

`ifdef TIMER_CTRL_LAP_EN
  logic [HW-1:0] lap_h_q;
  logic [MW-1:0] lap_m_q;
  logic [SW-1:0] lap_s_q;

  // Lap capture of current datapath time, cleared by clr from RUN/PAUSED
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lap_h_q <= '0;
      lap_m_q <= '0;
      lap_s_q <= '0;
    end else if (lap_clr) begin
      lap_h_q <= '0;
      lap_m_q <= '0;
      lap_s_q <= '0;
    end else if (lap_cap) begin
      lap_h_q <= i_hours;
      lap_m_q <= i_minutes;
      lap_s_q <= i_seconds;
    end
  end

  assign o_lap_hours   = lap_h_q;
  assign o_lap_minutes = lap_m_q;
  assign o_lap_seconds = lap_s_q;
`else
  logic unused_lap;
  assign unused_lap    = ^{i_btn_lap, lap_cap, lap_clr};
  assign o_lap_hours   = '0;
  assign o_lap_minutes = '0;
  assign o_lap_seconds = '0;
`endif

  // The only load value ever issued is 00:00:00.
  assign o_load_hours   = '0;
  assign o_load_minutes = '0;
  assign o_load_seconds = '0;

  assign o_run         = run_q;
  assign o_load        = load_q;
  assign o_alarm       = alarm_q;
  assign o_edit_field  = fld_q;
  assign o_tgt_hours   = tgt_h_q;
  assign o_tgt_minutes = tgt_m_q;
  assign o_tgt_seconds = tgt_s_q;

endmodule
